// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: instruction-fetch PC generator with a direct-mapped BTB.
//
// Holds the fetch PC and drives it to IMEM and to the branch predictor. A
// direct-mapped BTB identifies branches at the current PC and supplies their
// targets. The predictor's taken bit is qualified by a BTB hit to form the
// final prediction. Fetch is redirected when the ALU stage resolves a
// mispredicted branch.
//
// Parameters:
//   ADDRESS_WIDTH  - width of all PCs (word addresses)
//   BTB_INDEX_BITS - log2 of the BTB entry count
//   RESET_PC       - fetch PC loaded on reset
//
// Ports:
//   i_Clk, i_Reset         - clock; synchronous active-high reset
//   i_Stall                - hold PC and BTB, ignore ALU inputs
//   i_pred_taken           - predictor direction for the current PC
//   i_ALU_isbranch/outcome/prediction/pc/target/pred_target
//                          - resolution info for the ALU-stage branch
//   o_IMEM_address         - current fetch PC
//   o_isbranch_check       - BTB hit on current PC
//   o_pred_taken           - final predicted direction
//   o_pred_target          - predicted next PC
//   o_flush                - kill younger instructions this cycle
//
// Optional feature macro: FETCH_BTB_INVALIDATE_EN
//   When defined, a not-taken resolution invalidates a matching BTB entry.

module fetch_pc_gen #(
  parameter int unsigned                ADDRESS_WIDTH  = 22,
  parameter int unsigned                BTB_INDEX_BITS = 4,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC       = '0
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic                     i_Stall,
  input  logic                     i_pred_taken,
  input  logic                     i_ALU_isbranch,
  input  logic                     i_ALU_outcome,
  input  logic                     i_ALU_prediction,
  input  logic [ADDRESS_WIDTH-1:0] i_ALU_pc,
  input  logic [ADDRESS_WIDTH-1:0] i_ALU_target,
  input  logic [ADDRESS_WIDTH-1:0] i_ALU_pred_target,
  output logic [ADDRESS_WIDTH-1:0] o_IMEM_address,
  output logic                     o_isbranch_check,
  output logic                     o_pred_taken,
  output logic [ADDRESS_WIDTH-1:0] o_pred_target,
  output logic                     o_flush
);

  localparam int unsigned ENTRIES = 1 << BTB_INDEX_BITS;
  localparam int unsigned TAG_W   = ADDRESS_WIDTH - BTB_INDEX_BITS;
  localparam logic [ADDRESS_WIDTH-1:0] PC_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-1:0] next_pc;

  logic [ENTRIES-1:0]       btb_valid;
  logic [TAG_W-1:0]         btb_tag    [ENTRIES];
  logic [ADDRESS_WIDTH-1:0] btb_target [ENTRIES];

  logic [BTB_INDEX_BITS-1:0] fetch_idx;
  logic [TAG_W-1:0]          fetch_tag;
  logic [BTB_INDEX_BITS-1:0] alu_idx;
  logic [TAG_W-1:0]          alu_tag;

  logic hit;
  logic mispredict;
  logic btb_write;
  logic btb_inval;

  assign fetch_idx = pc[BTB_INDEX_BITS-1:0];
  assign fetch_tag = pc[ADDRESS_WIDTH-1:BTB_INDEX_BITS];
  assign alu_idx   = i_ALU_pc[BTB_INDEX_BITS-1:0];
  assign alu_tag   = i_ALU_pc[ADDRESS_WIDTH-1:BTB_INDEX_BITS];

  // Lookup reads the registered BTB, so a same-cycle write is seen next cycle.
  always_comb begin
    hit              = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);
    o_isbranch_check = hit;
    o_pred_taken     = hit && i_pred_taken;
    o_pred_target    = o_pred_taken ? btb_target[fetch_idx] : (pc + PC_ONE);
  end

  always_comb begin
    mispredict = i_ALU_isbranch && !i_Stall &&
                 ((i_ALU_outcome != i_ALU_prediction) ||
                  (i_ALU_outcome && (i_ALU_target != i_ALU_pred_target)));
    o_flush    = mispredict && !i_Reset;
    btb_write  = !i_Stall && i_ALU_isbranch && i_ALU_outcome;
`ifdef FETCH_BTB_INVALIDATE_EN
    btb_inval  = !i_Stall && i_ALU_isbranch && !i_ALU_outcome &&
                 btb_valid[alu_idx] && (btb_tag[alu_idx] == alu_tag);
`else
    btb_inval  = 1'b0;
`endif
  end

  always_comb begin
    next_pc = o_pred_target;
    if (mispredict) begin
      next_pc = i_ALU_outcome ? i_ALU_target : (i_ALU_pc + PC_ONE);
    end else if (i_Stall) begin
      next_pc = pc;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      pc        <= RESET_PC;
      btb_valid <= '0;
    end else begin
      pc <= next_pc;
      if (btb_write) begin
        btb_valid[alu_idx] <= 1'b1;
      end else if (btb_inval) begin
        btb_valid[alu_idx] <= 1'b0;
      end
    end
  end

  // Tag/target need no reset: they are only observed through a valid bit.
  always_ff @(posedge i_Clk) begin
    if (btb_write) begin
      btb_tag[alu_idx]    <= alu_tag;
      btb_target[alu_idx] <= i_ALU_target;
    end
  end

  assign o_IMEM_address = pc;

endmodule

// File: tb/tb_fetch_pc_gen.sv
module tb_fetch_pc_gen;

  localparam int AW = 22;
  localparam logic [AW-1:0] MASK = '1;

  logic          clk = 1'b0;
  logic          rst, stall, ptaken, isbr, outc, pred;
  logic [AW-1:0] apc, atgt, aptgt;
  logic [AW-1:0] imem, ptgt_o;
  logic          isbc, pt_o, flush;

  fetch_pc_gen #(
    .ADDRESS_WIDTH (22),
    .BTB_INDEX_BITS(4),
    .RESET_PC      (22'd0)
  ) dut (
    .i_Clk            (clk),
    .i_Reset          (rst),
    .i_Stall          (stall),
    .i_pred_taken     (ptaken),
    .i_ALU_isbranch   (isbr),
    .i_ALU_outcome    (outc),
    .i_ALU_prediction (pred),
    .i_ALU_pc         (apc),
    .i_ALU_target     (atgt),
    .i_ALU_pred_target(aptgt),
    .o_IMEM_address   (imem),
    .o_isbranch_check (isbc),
    .o_pred_taken     (pt_o),
    .o_pred_target    (ptgt_o),
    .o_flush          (flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          isb;
    logic          pt;
    logic [AW-1:0] tgt;
    logic          fl;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model: 16 slots selected by pc mod 16, each remembering the
  // full PC of the taken branch that last wrote it and its target.
  logic [AW-1:0] m_pc;
  bit            m_valid [16];
  logic [AW-1:0] m_bpc   [16];
  logic [AW-1:0] m_btgt  [16];

  task automatic chk(input string name, input logic [AW-1:0] got,
                     input logic [AW-1:0] exp, input int cyc);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("imem_address", imem, e.addr, e.cyc);
        chk("isbranch_check", {21'd0, isbc}, {21'd0, e.isb}, e.cyc);
        chk("pred_taken", {21'd0, pt_o}, {21'd0, e.pt}, e.cyc);
        chk("pred_target", ptgt_o, e.tgt, e.cyc);
        chk("flush", {21'd0, flush}, {21'd0, e.fl}, e.cyc);
      end
    end
  end

  // Drive one cycle (called just after a rising edge), record expectation,
  // advance the model, then wait for the next edge.
  task automatic step(input bit r, input bit s, input bit pt, input bit ib,
                      input bit oc, input bit pr, input logic [AW-1:0] p,
                      input logic [AW-1:0] t, input logic [AW-1:0] pt2);
    exp_t e;
    int   i;
    bit   h, mp;
    logic [AW-1:0] nxt;
    rst = r; stall = s; ptaken = pt; isbr = ib; outc = oc; pred = pr;
    apc = p; atgt = t; aptgt = pt2;
    i  = int'(m_pc % 16);
    h  = m_valid[i] && (m_bpc[i] == m_pc);
    mp = ib && !s && ((oc != pr) || (oc && t != pt2));
    e.addr = m_pc;
    e.isb  = h;
    e.pt   = h && pt;
    e.tgt  = (h && pt) ? m_btgt[i] : ((m_pc + 1) & MASK);
    e.fl   = mp && !r;
    e.cyc  = cycle;
    sb.push_back(e);
    if (r) begin
      nxt = '0;
      foreach (m_valid[k]) m_valid[k] = 0;
    end else begin
      if (mp)     nxt = oc ? t : ((p + 1) & MASK);
      else if (s) nxt = m_pc;
      else        nxt = e.tgt;
      i = int'(p % 16);
      if (!s && ib && oc) begin
        m_valid[i] = 1; m_bpc[i] = p; m_btgt[i] = t;
      end
`ifdef FETCH_BTB_INVALIDATE_EN
      if (!s && ib && !oc && m_valid[i] && m_bpc[i] == p) m_valid[i] = 0;
`endif
    end
    m_pc = nxt;
    @(posedge clk); #1;
    cycle++;
  endtask

  task automatic idle(input bit pt);
    step(0, 0, pt, 0, 0, 0, '0, '0, '0);
  endtask

  // Not-taken mispredict at p-1 steers fetch to p.
  task automatic goto_pc(input logic [AW-1:0] p);
    step(0, 0, 0, 1, 0, 1, (p - 1) & MASK, 22'h5, 22'h5);
  endtask

  initial begin
    logic [AW-1:0] rp, rt, rpt;
    bit rs, rr, ro, rpr, rib;
    rst = 1; stall = 0; ptaken = 0; isbr = 0; outc = 0; pred = 0;
    apc = '0; atgt = '0; aptgt = '0;
    @(posedge clk); #1;
    m_pc = '0;
    foreach (m_valid[k]) m_valid[k] = 0;

    // Reset then free-running fetch 0,1,2,3.
    step(1, 0, 0, 0, 0, 0, '0, '0, '0);
    repeat (4) idle(0);

    // Taken branch at 0x10 -> 0x40 mispredicted; refetch 0x10 predicted taken.
    step(0, 0, 0, 1, 1, 0, 22'h10, 22'h40, 22'h11);
    goto_pc(22'h10);
    idle(1);
    // Hit with predictor not-taken, then not-taken resolution at 0x10.
    goto_pc(22'h10);
    idle(0);
    step(0, 0, 0, 1, 0, 1, 22'h10, 22'h40, 22'h40);
    goto_pc(22'h10);
    idle(1);

    // Stall for 3 cycles with a mispredict presented, then release.
    repeat (3) step(0, 1, 0, 1, 1, 0, 22'h30, 22'h77, 22'h31);
    step(0, 0, 0, 1, 1, 0, 22'h30, 22'h77, 22'h31);
    idle(0);

    // PC wrap at all-ones.
    goto_pc('1);
    idle(0);
    idle(0);

    // Aliasing overwrite: 0x11 then 0x21 share entry 1.
    step(0, 0, 0, 1, 1, 0, 22'h11, 22'h99, 22'h12);
    step(0, 0, 0, 1, 1, 0, 22'h21, 22'hAA, 22'h22);
    goto_pc(22'h11);
    idle(1);
    goto_pc(22'h21);
    idle(1);

    // Reset during a mispredict.
    step(1, 0, 0, 1, 1, 0, 22'h21, 22'h55, 22'h22);
    goto_pc(22'h21);
    idle(1);

    // Randomised traffic, mostly in a small PC window to get BTB hits.
    repeat (3000) begin
      rr  = ($urandom_range(99) < 2);
      rs  = ($urandom_range(99) < 20);
      rib = ($urandom_range(99) < 40);
      ro  = $urandom_range(1);
      rpr = ($urandom_range(99) < 70) ? ro : !ro;
      case ($urandom_range(3))
        0: rp = m_pc;
        1: rp = (m_pc - 1) & MASK;
        2: rp = AW'($urandom_range(63));
        default: rp = AW'($urandom);
      endcase
      rt  = ($urandom_range(9) == 0) ? AW'($urandom) : AW'($urandom_range(63));
      rpt = ($urandom_range(99) < 70) ? rt : AW'($urandom_range(63));
      step(rr, rs, $urandom_range(1), rib, ro, rpr, rp, rt, rpt);
    end

    for (int n = 0; n < 10 && sb.size() > 0; n++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
